// File: rtl/bcd_counter_mod_n.sv
// Multi-digit BCD up/down counter with a configurable terminal value.
// Define BCD_COUNTER_LOAD_EN to compile in the checked parallel load.
module bcd_counter_mod_n #(
  parameter int DIGITS    = 2,
  parameter int MAX_VALUE = 59
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   value,
  output logic                  carry,
  output logic                  borrow,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
    $error("bcd_counter_mod_n: DIGITS out of range 1..6");
  end

  if (MAX_VALUE < 1 || MAX_VALUE > (10 ** DIGITS) - 1) begin : g_bad_max
    $error("bcd_counter_mod_n: MAX_VALUE out of range");
  end

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           n;
    r = '0;
    n = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  logic [W-1:0] value_d;
  logic         carry_d;
  logic         borrow_d;
  logic         err_d;

  always_comb begin
    value_d  = value;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
`ifdef BCD_COUNTER_LOAD_EN
    // With valid digits, BCD ordering matches unsigned vector ordering.
    if (load) begin
      if (digits_ok(load_val) && load_val <= MAX_BCD) begin
        value_d = load_val;
      end else begin
        err_d = 1'b1;
      end
    end else
`endif
    if (en) begin
      if (up) begin
        if (value == MAX_BCD) begin
          value_d = '0;
          carry_d = 1'b1;
        end else begin
          value_d = bcd_inc(value);
        end
      end else begin
        if (value == '0) begin
          value_d  = MAX_BCD;
          borrow_d = 1'b1;
        end else begin
          value_d = bcd_dec(value);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value  <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      value  <= value_d;
      carry  <= carry_d;
      borrow <= borrow_d;
    end
  end

`ifdef BCD_COUNTER_LOAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      load_err <= 1'b0;
    end else begin
      load_err <= err_d;
    end
  end
`else
  logic unused_load;
  assign unused_load = ^{load, load_val, err_d};
  assign load_err    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_counter_mod_n.sv
// Bench for bcd_counter_mod_n: integer model plus directed checks
// on 59, 23 and 999 terminal-value instances.
module tb_bcd_counter_mod_n;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  en;
  logic [2:0]  up;
  logic [2:0]  ld;
  logic [7:0]  lv0, lv1;
  logic [11:0] lv2;
  logic [7:0]  v0, v1;
  logic [11:0] v2;
  logic [2:0]  cy, bw, le;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_counter_mod_n #(.DIGITS(2), .MAX_VALUE(59)) u59 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .up(up[0]),
    .load(ld[0]), .load_val(lv0), .value(v0),
    .carry(cy[0]), .borrow(bw[0]), .load_err(le[0])
  );

  bcd_counter_mod_n #(.DIGITS(2), .MAX_VALUE(23)) u23 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .up(up[1]),
    .load(ld[1]), .load_val(lv1), .value(v1),
    .carry(cy[1]), .borrow(bw[1]), .load_err(le[1])
  );

  bcd_counter_mod_n #(.DIGITS(3), .MAX_VALUE(999)) u999 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .up(up[2]),
    .load(ld[2]), .load_val(lv2), .value(v2),
    .carry(cy[2]), .borrow(bw[2]), .load_err(le[2])
  );

  int mx[3] = '{59, 23, 999};
  int nd[3] = '{2, 2, 3};
  int mv[3];
  bit mc[3], mb[3], me[3];
  bit started[3] = '{0, 0, 0};

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int n;
    r = '0;
    n = v;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic [23:0] lv_of(input int i);
    if (i == 0) return {16'b0, lv0};
    if (i == 1) return {16'b0, lv1};
    return {12'b0, lv2};
  endfunction

  function automatic logic [23:0] val_of(input int i);
    if (i == 0) return {16'b0, v0};
    if (i == 1) return {16'b0, v1};
    return {12'b0, v2};
  endfunction

  // returns -1 when the word is not an acceptable load value
  function automatic int load_num(input logic [23:0] x, input int i);
    int num, scale, dig;
    num = 0;
    scale = 1;
    for (int d = 0; d < nd[i]; d++) begin
      dig = int'(x[4*d +: 4]);
      if (dig > 9) return -1;
      num += dig * scale;
      scale *= 10;
    end
    if (num > mx[i]) return -1;
    return num;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int n;
      n = load_num(lv_of(i), i);
      mc[i] = 0;
      mb[i] = 0;
      me[i] = 0;
      if (rst[i]) begin
        mv[i] = 0;
        started[i] = 1;
      end
`ifdef BCD_COUNTER_LOAD_EN
      else if (ld[i]) begin
        if (n >= 0) mv[i] = n;
        else me[i] = 1;
      end
`endif
      else if (en[i]) begin
        if (up[i]) begin
          if (mv[i] == mx[i]) begin
            mv[i] = 0;
            mc[i] = 1;
          end else begin
            mv[i] = mv[i] + 1;
          end
        end else begin
          if (mv[i] == 0) begin
            mv[i] = mx[i];
            mb[i] = 1;
          end else begin
            mv[i] = mv[i] - 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (started[i]) begin
        chk($sformatf("u%0d_value", i), 32'(val_of(i)), 32'(to_bcd(mv[i])));
        chk($sformatf("u%0d_carry", i), 32'(cy[i]), 32'(mc[i]));
        chk($sformatf("u%0d_borrow", i), 32'(bw[i]), 32'(mb[i]));
        chk($sformatf("u%0d_load_err", i), 32'(le[i]), 32'(me[i]));
      end
    end
  end

  initial begin
    rst = 3'b111;
    en  = '0;
    up  = '0;
    ld  = '0;
    lv0 = '0;
    lv1 = '0;
    lv2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_v59", 32'(v0), 32'h00);
    chk("rst_v23", 32'(v1), 32'h00);
    chk("rst_v999", 32'(v2), 32'h000);
    chk("rst_pulses", 32'({cy, bw, le}), 32'h0);

    rst = '0;
    en  = 3'b111;
    up  = 3'b001;
    @(negedge clk);
    chk("up_first", 32'(v0), 32'h01);
    chk("down_wrap_v", 32'(v1), 32'h23);
    chk("down_wrap_b", 32'(bw[1]), 32'h1);
    chk("d3_wrap_v", 32'(v2), 32'h999);

    up[2]  = 1'b1;
    rst[2] = 1'b1;
    @(negedge clk);
    chk("d3_rst_v", 32'(v2), 32'h000);
    chk("d3_rst_c", 32'(cy[2]), 32'h0);
    chk("down_22", 32'(v1), 32'h22);
    chk("down_b_low", 32'(bw[1]), 32'h0);

    rst[2] = 1'b0;
    up[2]  = 1'b0;
    @(negedge clk);
    up[2] = 1'b1;
    @(negedge clk);
    chk("d3_carry_v", 32'(v2), 32'h000);
    chk("d3_carry_c", 32'(cy[2]), 32'h1);
    en[2] = 1'b0;

    repeat (5) @(negedge clk);
    chk("up_09", 32'(v0), 32'h09);
    chk("down_15", 32'(v1), 32'h15);
    @(negedge clk);
    chk("up_10", 32'(v0), 32'h10);
    en[1] = 1'b0;

    repeat (49) @(negedge clk);
    chk("up_59", 32'(v0), 32'h59);
    chk("up_59_c", 32'(cy[0]), 32'h0);
    @(negedge clk);
    chk("wrap_00", 32'(v0), 32'h00);
    chk("wrap_c", 32'(cy[0]), 32'h1);
    @(negedge clk);
    chk("after_wrap", 32'(v0), 32'h01);
    chk("carry_drop", 32'(cy[0]), 32'h0);
    en[0] = 1'b0;

`ifdef BCD_COUNTER_LOAD_EN
    ld[0] = 1'b1;
    lv0   = 8'h45;
    @(negedge clk);
    chk("load_45", 32'(v0), 32'h45);
    ld[0] = 1'b0;
    en[0] = 1'b1;
    @(negedge clk);
    chk("load_step", 32'(v0), 32'h46);
    en[0] = 1'b0;
    ld[0] = 1'b1;
    lv0   = 8'h7A;
    @(negedge clk);
    chk("bad_digit_v", 32'(v0), 32'h46);
    chk("bad_digit_e", 32'(le[0]), 32'h1);
    lv0 = 8'h60;
    @(negedge clk);
    chk("over_max_v", 32'(v0), 32'h46);
    chk("over_max_e", 32'(le[0]), 32'h1);
    ld[0] = 1'b0;
    @(negedge clk);
    chk("err_drop", 32'(le[0]), 32'h0);
    ld[0] = 1'b1;
    lv0   = 8'h10;
    @(negedge clk);
    lv0   = 8'h59;
    en[0] = 1'b1;
    @(negedge clk);
    chk("ld_wins_v", 32'(v0), 32'h59);
    chk("ld_wins_c", 32'(cy[0]), 32'h0);
    ld[0] = 1'b0;
    @(negedge clk);
    chk("ld_then_wrap", 32'(v0), 32'h00);
    chk("ld_then_c", 32'(cy[0]), 32'h1);
    ld[0] = 1'b1;
    lv0   = 8'h7A;
    @(negedge clk);
    chk("rej_blocks_step", 32'(v0), 32'h00);
    ld[0] = 1'b0;
    en[0] = 1'b0;
`else
    ld[0] = 1'b1;
    lv0   = 8'h30;
    @(negedge clk);
    chk("ign_load_v", 32'(v0), 32'h01);
    chk("ign_load_e", 32'(le[0]), 32'h0);
    en[0] = 1'b1;
    @(negedge clk);
    chk("ign_load_step", 32'(v0), 32'h02);
    ld[0] = 1'b0;
    en[0] = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_counter_mod_n.md
# bcd_counter_mod_n

Parametrised multi-digit BCD up/down counter with a configurable terminal value. It generalises the fixed 00–99 counter used in the clock datapath. One instance covers seconds/minutes (0–59), hours (0–23), days (0–99) or wider fields. Instances cascade through `carry`/`borrow` into the next instance's `en`.

## Interface
- `DIGITS`, default 2: number of BCD digits; valid range 1–6.
- `MAX_VALUE`, default 59: terminal count as a decimal integer; valid range 1 to 10^DIGITS−1. Elaboration fails (`$error`) outside this range.

- `clk` input 1: clock, rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `en` input 1: count enable, one step per cycle while high.
- `up` input 1: direction; 1 = increment, 0 = decrement. Sampled only when `en`=1.
- `load` input 1: parallel load request (see Configuration).
- `load_val` input 4·DIGITS: BCD load value; digit 0 in bits [3:0].
- `value` output 4·DIGITS: registered BCD count; digit 0 = ones.
- `carry` output 1: one-cycle pulse on up-wrap MAX_VALUE→0.
- `borrow` output 1: one-cycle pulse on down-wrap 0→MAX_VALUE.
- `load_err` output 1: one-cycle pulse when a load request is rejected.

## Operation
- Reset (`rst`=1) takes priority over all other inputs.
  - `value`=0, `carry`=0, `borrow`=0, `load_err`=0.
  - Applies mid-count and mid-load; the pending step is discarded.
- Priority after reset: `load` > `en` > hold.
- `carry`, `borrow` and `load_err` default to 0 every cycle and are driven to 1 only by the event that defines them. They never stay high for two consecutive cycles unless the event repeats.
- Up step (`en`=1, `up`=1):
  - `value`==MAX_VALUE: `value`←0, `carry`←1.
  - Otherwise: BCD +1. Digit 9 becomes 0 and ripples +1 into the next digit within the same cycle.
- Down step (`en`=1, `up`=0):
  - `value`==0: `value`←MAX_VALUE (BCD encoded), `borrow`←1.
  - Otherwise: BCD −1. Digit 0 becomes 9 and ripples −1 into the next digit.
- MAX_VALUE is converted to a BCD constant at elaboration. The wrap comparison is a full-width equality on BCD, not a binary compare.
- `value` can never hold a non-BCD digit or exceed MAX_VALUE. Every path into the register preserves this invariant.
- Hold (`en`=0, no load): `value` is unchanged and all pulses are 0.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Step latency is 1 cycle: the effect of `en` sampled at edge N appears after edge N.
- `carry` and `borrow` assert in the same cycle that `value` shows the wrapped result. They are directly usable as `en` of the next stage, giving one-cycle cascade skew per stage.
- Load latency is 1 cycle; `load_err` appears in the same cycle the load would have taken effect.
- `load` and `en` in the same cycle: the load wins, the step is dropped, and no `carry` or `borrow` is produced.
- Back-to-back steps every cycle are supported; the maximum step rate is one per clock.

## Configuration
- Macro: `BCD_COUNTER_LOAD_EN`.
- Defined (load logic compiled in):
  - `load`=1 with `load_val` all digits ≤9 and value ≤ MAX_VALUE: `value`←`load_val`, `load_err`=0.
  - `load`=1 with any digit >9 or value > MAX_VALUE: `value` is unchanged and `load_err`←1 for one cycle.
  - A rejected load still suppresses a concurrent `en` step.
- Undefined:
  - `load` and `load_val` are ignored (ports kept, unused).
  - `load_err` is tied to 0.
  - `en` behaves as if `load`=0.

## Test plan
- DIGITS=2, MAX_VALUE=59, `en`=1, `up`=1 from reset → 00,01,…,09,10,…,58,59,00. `carry`=1 only in the cycle `value`=0x00 after 0x59.
- DIGITS=2, MAX_VALUE=23, `up`=0, `en`=1 from reset → 0x23 with `borrow`=1, then 0x22, …, 0x20, 0x19. `borrow` low after the first cycle.
- `BCD_COUNTER_LOAD_EN` defined, MAX_VALUE=59:
  - Load 0x45, then one up step → 0x46.
  - Load 0x7A → `load_err` pulse and `value` holds 0x46.
  - Load 0x60 → `load_err` pulse and `value` holds.
- Simultaneous `load`=1 (0x59) and `en`=1, `up`=1 at `value`=0x10 → 0x59 with `carry`=0. The next `en` cycle gives 0x00 with `carry`=1.
- DIGITS=3, MAX_VALUE=999 at 0x999, up step with `rst`=1 in the same cycle → 0x000 with `carry`=0. Without reset, the step gives 0x000 with `carry`=1.
- Macro undefined: `load`=1 with `load_val`=0x30 while `en`=0 → `value` unchanged and `load_err` stays 0.
